// File: rtl/btb_ctrl_if.sv
// Port bundle for btb_ctrl: fetch lookup, execute update, flush/status and the
// shared read/write ports of the tag, target and valid columns.
interface btb_ctrl_if #(
    parameter int unsigned idx_width = 6
);
    localparam int unsigned tag_width = 30 - idx_width;

    logic                 lk_valid;
    logic [31:0]          lk_pc;
    logic                 lk_hit;
    logic [31:0]          lk_target;

    logic                 upd_valid;
    logic                 upd_ready;
    logic [31:0]          upd_pc;
    logic [31:0]          upd_target;
    logic                 upd_taken;
    logic                 upd_pred_hit;

    logic                 flush_req;
    logic                 busy;
    logic                 flush_done;
    logic [31:0]          hit_count;

    logic                 col_read;
    logic [idx_width-1:0] col_r_idx;
    logic                 col_load;
    logic [idx_width-1:0] col_w_idx;
    logic [tag_width-1:0] col_tag_in;
    logic [31:0]          col_tgt_in;
    logic                 col_vld_in;
    logic [tag_width-1:0] col_tag_out;
    logic [31:0]          col_tgt_out;
    logic                 col_vld_out;

    modport slave (
        input  lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_pred_hit,
               flush_req, col_tag_out, col_tgt_out, col_vld_out,
        output lk_hit, lk_target, upd_ready, busy, flush_done, hit_count,
               col_read, col_r_idx, col_load, col_w_idx, col_tag_in, col_tgt_in, col_vld_in
    );

    modport master (
        output lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_pred_hit,
               flush_req, col_tag_out, col_tgt_out, col_vld_out,
        input  lk_hit, lk_target, upd_ready, busy, flush_done, hit_count,
               col_read, col_r_idx, col_load, col_w_idx, col_tag_in, col_tgt_in, col_vld_in
    );
endinterface

// File: rtl/btb_ctrl.sv
// Direct-mapped BTB controller: same-cycle lookup, 2-entry update queue drained into
// the columns one entry per cycle, and the INIT/FLUSH invalidation sweep.
module btb_ctrl #(
    parameter int unsigned idx_width = 6
) (
    input logic       clk,
    input logic       rst_n,
    btb_ctrl_if.slave bus
);
    localparam int unsigned tag_width = 30 - idx_width;

    typedef enum logic [1:0] {StInit, StIdle, StFlush} state_e;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        pred_hit;
    } upd_t;

    state_e               state;
    logic [idx_width-1:0] walker;
    upd_t                 q [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           count;
    logic                 sweep;
    logic                 push;
    logic                 pop;
    upd_t                 head;
    logic [tag_width-1:0] lk_tag;
    logic                 unused_pc_bits;

    // Word alignment bits never reach the BTB.
    assign unused_pc_bits = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

    assign sweep         = (state != StIdle);
    assign bus.busy      = sweep;
    assign bus.upd_ready = (count != 2'd2);
    assign push          = bus.upd_valid & bus.upd_ready & ~bus.flush_req;
    assign pop           = ~sweep & (count != 2'd0);
    assign head          = q[rd_ptr];

    assign lk_tag        = bus.lk_pc[31:idx_width+2];
    assign bus.col_read  = bus.lk_valid;
    assign bus.col_r_idx = bus.lk_pc[idx_width+1:2];
    assign bus.lk_hit    = bus.lk_valid & (state == StIdle) & bus.col_vld_out &
                           (bus.col_tag_out == lk_tag);
    assign bus.lk_target = bus.lk_hit ? bus.col_tgt_out : 32'h0;

    // Sweep owns the write port; the queue only drains in IDLE.
    always_comb begin
        bus.col_load   = 1'b0;
        bus.col_w_idx  = '0;
        bus.col_tag_in = '0;
        bus.col_tgt_in = '0;
        bus.col_vld_in = 1'b0;
        if (sweep) begin
            bus.col_load  = rst_n;
            bus.col_w_idx = walker;
        end else if (count != 2'd0) begin
            bus.col_w_idx = head.pc[idx_width-1:0];
            if (head.taken) begin
                bus.col_load   = 1'b1;
                bus.col_tag_in = head.pc[29:idx_width];
                bus.col_tgt_in = head.target;
                bus.col_vld_in = 1'b1;
            end else if (head.pred_hit) begin
                bus.col_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StInit;
            walker         <= '0;
            bus.flush_done <= 1'b0;
            bus.hit_count  <= 32'h0;
        end else begin
            bus.flush_done <= 1'b0;
            if (bus.lk_hit && (bus.hit_count != 32'hFFFF_FFFF)) begin
                bus.hit_count <= bus.hit_count + 32'd1;
            end
            if (bus.flush_req) begin
                state  <= StFlush;
                walker <= '0;
            end else if (sweep) begin
                if (&walker) begin
                    state          <= StIdle;
                    walker         <= '0;
                    bus.flush_done <= 1'b1;
                end else begin
                    walker <= walker + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (bus.flush_req) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Entry storage needs no reset: count gates every use.
    always_ff @(posedge clk) begin
        if (push) begin
            q[wr_ptr] <= '{pc:       bus.upd_pc[31:2],
                           target:   bus.upd_target,
                           taken:    bus.upd_taken,
                           pred_hit: bus.upd_pred_hit};
        end
    end
endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl with behavioural column arrays and a set-level
// reference model of the BTB contents, update queue and sweep.
module tb_btb_ctrl;
    localparam int IW = 6;
    localparam int NS = 64;
    localparam int TW = 30 - IW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btb_ctrl_if #(.idx_width(IW)) bus ();
    btb_ctrl #(.idx_width(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Column arrays with write-to-read bypass; seeded with stale valid entries.
    logic [TW-1:0] ctag [NS];
    logic [31:0]   ctgt [NS];
    logic          cvld [NS];
    bit            seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < NS; i++) begin
                ctag[i] <= TW'($urandom_range(0, 3));
                ctgt[i] <= $urandom;
                cvld[i] <= 1'b1;
            end
            seeded <= 1'b1;
        end else if (bus.col_load) begin
            ctag[bus.col_w_idx] <= bus.col_tag_in;
            ctgt[bus.col_w_idx] <= bus.col_tgt_in;
            cvld[bus.col_w_idx] <= bus.col_vld_in;
        end
    end

    always_comb begin
        if (bus.col_load && (bus.col_w_idx == bus.col_r_idx)) begin
            bus.col_tag_out = bus.col_tag_in;
            bus.col_tgt_out = bus.col_tgt_in;
            bus.col_vld_out = bus.col_vld_in;
        end else begin
            bus.col_tag_out = ctag[bus.col_r_idx];
            bus.col_tgt_out = ctgt[bus.col_r_idx];
            bus.col_vld_out = cvld[bus.col_r_idx];
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        pred_hit;
    } ent_t;

    ent_t          mq[$];
    logic [TW-1:0] mtag [NS];
    logic [31:0]   mtgt [NS];
    bit            mvld [NS];
    int            sweep_pos;
    bit            mdone;
    logic [31:0]   mhits;
    int            checks = 0;
    int            failures = 0;

    logic          s_hit, s_ready, s_load, s_busy, s_done;
    logic [31:0]   s_tgt, s_hc;
    logic [IW-1:0] s_widx;

    task automatic model_reset();
        mq.delete();
        sweep_pos = 0;
        mdone = 1'b0;
        mhits = 32'h0;
        for (int i = 0; i < NS; i++) mvld[i] = 1'b0;
    endtask

    task automatic sample();
        bit exp_load, exp_vld, exp_hit, accept, zero_data;
        int widx, li;
        logic [TW-1:0] wtag;
        logic [31:0] wtgt, exp_tgt;
        @(negedge clk);
        s_hit = bus.lk_hit; s_tgt = bus.lk_target; s_ready = bus.upd_ready;
        s_load = bus.col_load; s_widx = bus.col_w_idx; s_busy = bus.busy;
        s_done = bus.flush_done; s_hc = bus.hit_count;
        if (!rst_n) begin
            checks++;
            if ({bus.busy, bus.upd_ready, bus.flush_done, bus.lk_hit, bus.col_load} !== 5'b11000
                || bus.hit_count !== 32'h0) begin
                failures++;
                $display("FAIL reset_values got busy/rdy/done/hit/load=%b%b%b%b%b hc=%h exp 11000 0",
                         bus.busy, bus.upd_ready, bus.flush_done, bus.lk_hit, bus.col_load,
                         bus.hit_count);
            end
            model_reset();
            return;
        end
        exp_load = 0; exp_vld = 0; widx = 0; wtag = '0; wtgt = '0; zero_data = 0;
        if (sweep_pos >= 0) begin
            exp_load = 1; widx = sweep_pos; zero_data = 1;
        end else if (mq.size() > 0) begin
            widx = int'(mq[0].pc[IW+1:2]);
            if (mq[0].taken) begin
                exp_load = 1; exp_vld = 1; wtag = mq[0].pc[31:IW+2]; wtgt = mq[0].target;
            end else if (mq[0].pred_hit) begin
                exp_load = 1;
            end
        end
        checks++;
        if (bus.col_load !== exp_load) begin
            failures++;
            $display("FAIL col_load got=%b exp=%b", bus.col_load, exp_load);
        end
        if (exp_load) begin
            checks++;
            if ({bus.col_w_idx, bus.col_vld_in} !== {IW'(widx), exp_vld}) begin
                failures++;
                $display("FAIL col_write idx/vld got=%0d/%b exp=%0d/%b",
                         bus.col_w_idx, bus.col_vld_in, widx, exp_vld);
            end
            if (exp_vld || zero_data) begin
                checks++;
                if (bus.col_tag_in !== wtag || bus.col_tgt_in !== wtgt) begin
                    failures++;
                    $display("FAIL col_data got tag=%h tgt=%h exp tag=%h tgt=%h",
                             bus.col_tag_in, bus.col_tgt_in, wtag, wtgt);
                end
            end
            mvld[widx] = exp_vld; mtag[widx] = wtag; mtgt[widx] = wtgt;
        end
        checks++;
        if ({bus.busy, bus.upd_ready, bus.flush_done} !==
            {sweep_pos >= 0, mq.size() < 2, mdone}) begin
            failures++;
            $display("FAIL status busy/rdy/done got=%b%b%b exp=%b%b%b", bus.busy,
                     bus.upd_ready, bus.flush_done, sweep_pos >= 0, mq.size() < 2, mdone);
        end
        li = int'(bus.lk_pc[IW+1:2]);
        exp_hit = bus.lk_valid && sweep_pos < 0 && mvld[li] && mtag[li] == bus.lk_pc[31:IW+2];
        exp_tgt = exp_hit ? mtgt[li] : 32'h0;
        checks++;
        if (bus.col_read !== bus.lk_valid || bus.col_r_idx !== bus.lk_pc[IW+1:2]) begin
            failures++;
            $display("FAIL col_read got=%b/%0d exp=%b/%0d", bus.col_read, bus.col_r_idx,
                     bus.lk_valid, bus.lk_pc[IW+1:2]);
        end
        checks++;
        if (bus.lk_hit !== exp_hit || bus.lk_target !== exp_tgt) begin
            failures++;
            $display("FAIL lookup pc=%h got hit=%b tgt=%h exp hit=%b tgt=%h", bus.lk_pc,
                     bus.lk_hit, bus.lk_target, exp_hit, exp_tgt);
        end
        checks++;
        if (bus.hit_count !== mhits) begin
            failures++;
            $display("FAIL hit_count got=%0d exp=%0d", bus.hit_count, mhits);
        end
        if (exp_hit && mhits != 32'hFFFF_FFFF) mhits++;
        accept = bus.upd_valid && mq.size() < 2 && !bus.flush_req;
        mdone = 1'b0;
        if (bus.flush_req) begin
            sweep_pos = 0;
            mq.delete();
        end else begin
            if (sweep_pos >= 0) begin
                if (sweep_pos == NS - 1) begin
                    sweep_pos = -1; mdone = 1'b1;
                end else begin
                    sweep_pos++;
                end
            end else if (mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (accept) mq.push_back('{bus.upd_pc, bus.upd_target, bus.upd_taken,
                                       bus.upd_pred_hit});
        end
    endtask

    task automatic step();
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lk_valid = 0; bus.lk_pc = '0; bus.upd_valid = 0; bus.upd_pc = '0;
        bus.upd_target = '0; bus.upd_taken = 0; bus.upd_pred_hit = 0; bus.flush_req = 0;
    endtask

    function automatic logic [31:0] rand_pc();
        return {24'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
    endfunction

    task automatic run_init(input string name);
        int busy_cycles = 0;
        for (int i = 0; i < NS; i++) begin
            bus.lk_valid = 1; bus.lk_pc = rand_pc();
            step();
            if (s_busy) busy_cycles++;
        end
        bus.lk_valid = 0;
        step();
        checks++;
        if (busy_cycles != NS || s_busy !== 1'b0 || s_done !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_cycles=%0d busy=%b done=%b exp 64/0/1", name, busy_cycles,
                     s_busy, s_done);
        end
        step();
        checks++;
        if (s_done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse_width got=%b exp=0", name, s_done);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) step();
        rst_n = 1;
        run_init("init");
    endtask

    task automatic test_taken();
        logic [31:0] hc0;
        bus.upd_valid = 1; bus.upd_pc = 32'h0000_1040; bus.upd_target = 32'h2000;
        bus.upd_taken = 1; bus.upd_pred_hit = 0;
        step();
        bus.upd_valid = 0; bus.lk_valid = 1; bus.lk_pc = 32'h0000_1040;
        step();
        hc0 = s_hc;
        checks++;
        if (s_load !== 1'b1 || s_hit !== 1'b1 || s_tgt !== 32'h2000) begin
            failures++;
            $display("FAIL bypass_hit got load=%b hit=%b tgt=%h exp 1 1 2000", s_load, s_hit,
                     s_tgt);
        end
        step();
        checks++;
        if (s_hit !== 1'b1 || s_tgt !== 32'h2000 || s_hc !== hc0 + 1) begin
            failures++;
            $display("FAIL stored_hit got hit=%b tgt=%h hc=%0d exp 1 2000 %0d", s_hit, s_tgt,
                     s_hc, hc0 + 1);
        end
        bus.lk_pc = 32'h0001_1040;
        step();
        checks++;
        if (s_hit !== 1'b0 || s_tgt !== 32'h0) begin
            failures++;
            $display("FAIL tag_miss got hit=%b tgt=%h exp 0 0", s_hit, s_tgt);
        end
        idle_inputs();
    endtask

    task automatic test_not_taken();
        bus.upd_valid = 1; bus.upd_pc = 32'h0000_1040; bus.upd_target = 32'h2000;
        bus.upd_taken = 0; bus.upd_pred_hit = 1;
        step();
        bus.upd_valid = 0; bus.lk_valid = 1; bus.lk_pc = 32'h0000_1040;
        step();
        checks++;
        if (s_load !== 1'b1 || s_hit !== 1'b0) begin
            failures++;
            $display("FAIL invalidate got load=%b hit=%b exp 1 0", s_load, s_hit);
        end
        bus.upd_valid = 1; bus.upd_pred_hit = 0;
        step();
        bus.upd_valid = 0;
        step();
        checks++;
        if (s_load !== 1'b0) begin
            failures++;
            $display("FAIL no_write_pop got load=%b exp 0", s_load);
        end
        idle_inputs();
    endtask

    task automatic test_flush_restart();
        logic [2:0] rdy;
        logic [31:0] pcs [3];
        int n;
        pcs[0] = 32'h0000_3008; pcs[1] = 32'h0000_500C; pcs[2] = 32'h0000_7010;
        bus.flush_req = 1;
        step();
        bus.flush_req = 0;
        repeat (20) step();
        bus.flush_req = 1;
        step();
        checks++;
        if (s_widx !== IW'(20) || s_busy !== 1'b1) begin
            failures++;
            $display("FAIL walker_at_20 got=%0d busy=%b exp 20 1", s_widx, s_busy);
        end
        bus.flush_req = 0;
        step();
        checks++;
        if (s_widx !== '0) begin
            failures++;
            $display("FAIL walker_restart got=%0d exp=0", s_widx);
        end
        for (int k = 0; k < 3; k++) begin
            bus.upd_valid = 1; bus.upd_pc = pcs[k]; bus.upd_target = 32'hA000 + k;
            bus.upd_taken = 1; bus.upd_pred_hit = 0;
            step();
            rdy[k] = s_ready;
        end
        bus.upd_valid = 0;
        checks++;
        if (rdy !== 3'b011) begin
            failures++;
            $display("FAIL queue_full ready[2:0] got=%b exp=011", rdy);
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!s_done && n < 200);
        checks++;
        if (!s_done) begin
            failures++;
            $display("FAIL flush_done_timeout got=0 exp=1");
        end
        bus.lk_valid = 1; bus.lk_pc = pcs[1];
        step();
        checks++;
        if (s_hit !== 1'b1 || s_tgt !== 32'hA001) begin
            failures++;
            $display("FAIL drain_second got hit=%b tgt=%h exp 1 a001", s_hit, s_tgt);
        end
        bus.lk_pc = pcs[0];
        step();
        checks++;
        if (s_hit !== 1'b1 || s_tgt !== 32'hA000) begin
            failures++;
            $display("FAIL drain_first got hit=%b tgt=%h exp 1 a000", s_hit, s_tgt);
        end
        bus.lk_pc = pcs[2];
        step();
        checks++;
        if (s_hit !== 1'b0) begin
            failures++;
            $display("FAIL dropped_third got hit=%b exp 0", s_hit);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.flush_req = 1;
        step();
        bus.flush_req = 0;
        for (int i = 0; i < 30; i++) begin
            bus.upd_valid = (i == 25); bus.upd_pc = 32'h0000_0104; bus.upd_target = 32'h55;
            bus.upd_taken = 1;
            step();
        end
        bus.upd_valid = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({bus.busy, bus.upd_ready, bus.flush_done, bus.lk_hit, bus.col_load} !== 5'b11000
            || bus.hit_count !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got busy/rdy/done/hit/load=%b%b%b%b%b hc=%h exp 11000 0",
                     bus.busy, bus.upd_ready, bus.flush_done, bus.lk_hit, bus.col_load,
                     bus.hit_count);
        end
        step();
        rst_n = 1;
        run_init("reinit");
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        for (int i = 0; i < 24; i++) begin
            bus.upd_valid = 1; bus.upd_pc = rand_pc(); bus.upd_target = $urandom;
            bus.upd_taken = 1; bus.upd_pred_hit = 0;
            bus.lk_valid = 1; bus.lk_pc = rand_pc();
            step();
            if (!s_ready) stalls++;
        end
        idle_inputs();
        step();
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("FAIL back_to_back stalls got=%0d exp=0", stalls);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            bus.lk_valid = 1'($urandom_range(0, 3) != 0); bus.lk_pc = rand_pc();
            bus.upd_valid = 1'($urandom_range(0, 1)); bus.upd_pc = rand_pc();
            bus.upd_target = $urandom; bus.upd_taken = 1'($urandom_range(0, 2) != 0);
            bus.upd_pred_hit = 1'($urandom_range(0, 1));
            bus.flush_req = ($urandom_range(0, 149) == 0);
            step();
        end
        idle_inputs();
        repeat (70) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_taken();
        test_not_taken();
        test_flush_restart();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btb_ctrl.md
# btb_ctrl

Controller for the direct-mapped branch target buffer built from three `btb_col` arrays: tag, target and valid. Fetch sends it a PC and it answers hit/target in the same cycle. Resolved-branch updates from execute go into a 2-entry queue and are drained into the columns one per cycle. The block also runs the post-reset and fence/flush invalidation sweep, which writes valid=0 to every set.

## Interface
- `idx_width`, 6, set index width; n_sets = 2**idx_width
- `tag_width`, 30-idx_width, tag bits taken from pc[31:idx_width+2]
- `clk` in 1 system clock, rising edge
- `rst_n` in 1 reset, asynchronous, active-low
- `lk_valid` in 1 fetch lookup request
- `lk_pc` in 32 fetch PC
- `lk_hit` out 1 BTB hit for lk_pc
- `lk_target` out 32 predicted target, valid when lk_hit
- `upd_valid` in 1 execute update request
- `upd_ready` out 1 update queue can accept
- `upd_pc` in 32 branch PC
- `upd_target` in 32 resolved target
- `upd_taken` in 1 branch resolved taken
- `upd_pred_hit` in 1 this branch hit the BTB at fetch
- `flush_req` in 1 one-cycle invalidate-all request
- `busy` out 1 INIT or FLUSH sweep in progress
- `flush_done` out 1 one-cycle pulse at sweep end
- `hit_count` out 32 saturating lookup-hit counter
- `col_read` out 1 read enable to all columns
- `col_r_idx` out idx_width read index
- `col_load` out 1 write enable to all columns
- `col_w_idx` out idx_width write index
- `col_tag_in` out tag_width; `col_tgt_in` out 32; `col_vld_in` out 1; these are the write data
- `col_tag_out` in tag_width; `col_tgt_out` in 32; `col_vld_out` in 1; these are the read data

## Operation
- Address split: idx = pc[idx_width+1:2], tag = pc[31:idx_width+2].
- States: INIT, IDLE, FLUSH. Reset enters INIT.
- INIT/FLUSH sweep:
  - A walker counter runs 0 to n_sets-1, one set per cycle.
  - Each cycle drives col_load=1, col_w_idx=walker, col_vld_in=0, tag/target=0.
  - After the last index the state goes to IDLE and flush_done pulses for one cycle. This happens for INIT too.
- flush_req:
  - In any state it enters FLUSH with walker=0. During a sweep this restarts the sweep.
  - It empties the update queue on the same edge.
  - An update handshaken in the same cycle as flush_req is discarded.
- Lookup (combinational):
  - col_read=lk_valid and col_r_idx=lk_pc idx.
  - lk_hit = lk_valid & state==IDLE & col_vld_out & col_tag_out==tag.
  - lk_target = col_tgt_out when hit, else 0.
- Update queue:
  - 2-entry FIFO of {pc, target, taken, pred_hit}.
  - upd_ready = not full. No push when full, even if a pop happens the same cycle.
- Drain, IDLE only, one entry per cycle when the queue is non-empty:
  - taken: write tag, target and valid=1 at idx.
  - not taken & pred_hit: write valid=0 at idx.
  - not taken & !pred_hit: pop with no write (col_load=0).
- Write-port priority: sweep, then drain. The queue holds during sweeps.
- hit_count:
  - +1 per cycle with lk_hit=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.

## Timing
- Reset values: state INIT, walker 0, queue empty, upd_ready 1, busy 1, flush_done 0, lk_hit 0, hit_count 0, col_load 0 while rst_n low.
- INIT takes n_sets cycles after rst_n rises. flush_done is high in cycle n_sets+1 (first IDLE cycle).
- Update accepted at edge N is written at the earliest in cycle N+1.
- A same-cycle lookup to that index sees the new data through the column bypass (r_idx==w_idx forwards write data).
- Back-to-back updates sustain 1 per cycle in IDLE.
- Queue fills only while a sweep is running.
- rst_n assertion mid-sweep or mid-drain:
  - All state clears immediately.
  - Queued updates are lost.
  - INIT restarts on release.

## Test plan
- Reset release, idx_width=6: busy=1 for 64 cycles; col_w_idx steps 0..63 with col_vld_in=0; flush_done pulses one cycle; busy falls; lookups before that return lk_hit=0.
- Taken update pc=0x0000_1040, target=0x2000: written in the next cycle; lookup 0x1040 -> hit, target 0x2000; lookup 0x0001_1040 (same idx, different tag) -> miss.
- Update then same-cycle lookup of the drained index -> hit via bypass; hit_count increments by 1.
- Not-taken, pred_hit=1 on the entry above -> valid cleared, lookup misses. Not-taken, pred_hit=0 -> col_load stays 0.
- flush_req mid-FLUSH at walker=20 -> walker restarts at 0; three updates offered during the sweep -> two accepted, upd_ready=0 on the third, both drained after flush_done.
- rst_n pulsed low at walker=30 -> outputs go to reset values immediately; a full 64-cycle INIT follows.
